// File: rtl/mmu_client_if.sv
// Host/MMU-facing bundle for mmu_client: command in, MMU request/response FIFO ports, result out.
// slave is the client's view, master is the host/MMU side.
interface mmu_client_if #(
  parameter int unsigned ID_W    = 13,
  parameter int unsigned IDX_W   = 15,
  parameter int unsigned SZ_W    = 4,
  parameter int unsigned FR_W    = 2,
  parameter int unsigned MAX_OUT = 16
);
  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_is_free;
  logic [SZ_W-1:0]  cmd_page_count;
  logic [IDX_W-1:0] cmd_page_idx;

  logic             alloc_req_submit;
  logic [ID_W-1:0]  alloc_req_id;
  logic [SZ_W-1:0]  alloc_req_page_count;
  logic             free_req_submit;
  logic [ID_W-1:0]  free_req_id;
  logic [IDX_W-1:0] free_req_page_idx;
  logic [SZ_W-1:0]  free_req_page_count;
  logic             alloc_req_fifo_full;
  logic             free_req_fifo_full;

  logic             alloc_rsp_fifo_not_empty;
  logic             free_rsp_fifo_not_empty;
  logic             alloc_rsp_pop;
  logic             free_rsp_pop;
  logic [ID_W-1:0]  alloc_rsp_id;
  logic [IDX_W-1:0] alloc_rsp_page_idx;
  logic             alloc_rsp_fail;
  logic [FR_W-1:0]  alloc_rsp_fail_reason;
  logic [SZ_W-1:0]  alloc_rsp_origin_size;
  logic [SZ_W-1:0]  alloc_rsp_actual_size;
  logic [ID_W-1:0]  free_rsp_id;
  logic             free_rsp_fail;
  logic [FR_W-1:0]  free_rsp_fail_reason;
  logic [SZ_W-1:0]  free_rsp_origin_size;
  logic [SZ_W-1:0]  free_rsp_actual_size;

  logic             res_valid;
  logic             res_ready;
  logic             res_is_free;
  logic [ID_W-1:0]  res_id;
  logic [IDX_W-1:0] res_page_idx;
  logic             res_fail;
  logic [FR_W-1:0]  res_fail_reason;
  logic [SZ_W-1:0]  res_origin_size;
  logic [SZ_W-1:0]  res_actual_size;

  logic [CNT_W-1:0] alloc_outstanding;
  logic [CNT_W-1:0] free_outstanding;
  logic             err_id_mismatch;
  logic             err_unexpected_rsp;
  logic             err_clear;

  modport slave (
    input  cmd_valid, cmd_is_free, cmd_page_count, cmd_page_idx,
    output cmd_ready,
    output alloc_req_submit, alloc_req_id, alloc_req_page_count,
    output free_req_submit, free_req_id, free_req_page_idx, free_req_page_count,
    input  alloc_req_fifo_full, free_req_fifo_full,
    input  alloc_rsp_fifo_not_empty, free_rsp_fifo_not_empty,
    output alloc_rsp_pop, free_rsp_pop,
    input  alloc_rsp_id, alloc_rsp_page_idx, alloc_rsp_fail, alloc_rsp_fail_reason,
    input  alloc_rsp_origin_size, alloc_rsp_actual_size,
    input  free_rsp_id, free_rsp_fail, free_rsp_fail_reason, free_rsp_origin_size,
    input  free_rsp_actual_size,
    output res_valid, res_is_free, res_id, res_page_idx, res_fail, res_fail_reason,
    output res_origin_size, res_actual_size,
    input  res_ready,
    output alloc_outstanding, free_outstanding, err_id_mismatch, err_unexpected_rsp,
    input  err_clear
  );

  modport master (
    output cmd_valid, cmd_is_free, cmd_page_count, cmd_page_idx,
    input  cmd_ready,
    input  alloc_req_submit, alloc_req_id, alloc_req_page_count,
    input  free_req_submit, free_req_id, free_req_page_idx, free_req_page_count,
    output alloc_req_fifo_full, free_req_fifo_full,
    output alloc_rsp_fifo_not_empty, free_rsp_fifo_not_empty,
    input  alloc_rsp_pop, free_rsp_pop,
    output alloc_rsp_id, alloc_rsp_page_idx, alloc_rsp_fail, alloc_rsp_fail_reason,
    output alloc_rsp_origin_size, alloc_rsp_actual_size,
    output free_rsp_id, free_rsp_fail, free_rsp_fail_reason, free_rsp_origin_size,
    output free_rsp_actual_size,
    input  res_valid, res_is_free, res_id, res_page_idx, res_fail, res_fail_reason,
    input  res_origin_size, res_actual_size,
    output res_ready,
    input  alloc_outstanding, free_outstanding, err_id_mismatch, err_unexpected_rsp,
    output err_clear
  );
endinterface

// File: rtl/mmu_client.sv
// Requester-side MMU agent: zero-latency request submit with per-channel ids, and a
// round-robin response collector that returns one result at a time on a valid/ready port.
module mmu_client #(
  parameter int unsigned ID_W    = 13,
  parameter int unsigned IDX_W   = 15,
  parameter int unsigned SZ_W    = 4,
  parameter int unsigned FR_W    = 2,
  parameter int unsigned MAX_OUT = 16
) (
  input logic        clk,
  input logic        rst_n,
  mmu_client_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_CAPT, S_HOLD} state_e;

  state_e           r_state;
  logic             r_last_free;
  logic             r_sel_free;
  logic [ID_W-1:0]  r_alloc_id, r_free_id;
  logic [ID_W-1:0]  r_exp_alloc, r_exp_free;
  logic [CNT_W-1:0] r_alloc_out, r_free_out;
  logic             r_err_mm, r_err_ux;
  logic             r_res_valid, r_res_is_free, r_res_fail;
  logic [ID_W-1:0]  r_res_id;
  logic [IDX_W-1:0] r_res_page_idx;
  logic [FR_W-1:0]  r_res_fail_reason;
  logic [SZ_W-1:0]  r_res_origin_size, r_res_actual_size;

  logic             w_alloc_ok, w_free_ok, w_ready;
  logic             w_alloc_sub, w_free_sub;
  logic             w_grant_free, w_alloc_pop, w_free_pop;
  logic             w_alloc_ux, w_free_ux, w_mm;
  logic [CNT_W-1:0] w_alloc_out_nx, w_free_out_nx;
  logic [ID_W-1:0]  w_cap_id, w_exp_id;

  // Returns {pop_at_zero, next_count}; submit and pop together cancel out.
  function automatic logic [CNT_W:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                              input logic sub, input logic pop);
    logic [CNT_W:0] r;
    r = {1'b0, cnt};
    if (sub && !pop) begin
      r = {1'b0, cnt + CNT_W'(1)};
    end else if (!sub && pop) begin
      if (cnt == '0) r = {1'b1, cnt};
      else           r = {1'b0, cnt - CNT_W'(1)};
    end
    return r;
  endfunction

  assign w_alloc_ok  = ~bus.alloc_req_fifo_full & (r_alloc_out < CNT_W'(MAX_OUT));
  assign w_free_ok   = ~bus.free_req_fifo_full & (r_free_out < CNT_W'(MAX_OUT));
  assign w_ready     = bus.cmd_is_free ? w_free_ok : w_alloc_ok;
  assign w_alloc_sub = bus.cmd_valid & w_ready & ~bus.cmd_is_free;
  assign w_free_sub  = bus.cmd_valid & w_ready & bus.cmd_is_free;

  assign bus.cmd_ready            = w_ready;
  assign bus.alloc_req_submit     = w_alloc_sub;
  assign bus.alloc_req_id         = r_alloc_id;
  assign bus.alloc_req_page_count = bus.cmd_page_count;
  assign bus.free_req_submit      = w_free_sub;
  assign bus.free_req_id          = r_free_id;
  assign bus.free_req_page_idx    = bus.cmd_page_idx;
  assign bus.free_req_page_count  = bus.cmd_page_count;

  // On a tie the channel not granted last time wins.
  assign w_grant_free = bus.free_rsp_fifo_not_empty & (~bus.alloc_rsp_fifo_not_empty | ~r_last_free);
  assign w_alloc_pop  = (r_state == S_IDLE) & bus.alloc_rsp_fifo_not_empty & ~w_grant_free;
  assign w_free_pop   = (r_state == S_IDLE) & w_grant_free;
  assign bus.alloc_rsp_pop = w_alloc_pop;
  assign bus.free_rsp_pop  = w_free_pop;

  assign {w_alloc_ux, w_alloc_out_nx} = cnt_step(r_alloc_out, w_alloc_sub, w_alloc_pop);
  assign {w_free_ux, w_free_out_nx}   = cnt_step(r_free_out, w_free_sub, w_free_pop);

  assign w_cap_id = r_sel_free ? bus.free_rsp_id : bus.alloc_rsp_id;
  assign w_exp_id = r_sel_free ? r_exp_free : r_exp_alloc;
  assign w_mm     = (r_state == S_CAPT) & (w_cap_id != w_exp_id);

  // Request ids, outstanding counts and sticky error flags; a same-cycle set beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alloc_id  <= '0;
      r_free_id   <= '0;
      r_alloc_out <= '0;
      r_free_out  <= '0;
      r_err_mm    <= 1'b0;
      r_err_ux    <= 1'b0;
    end else begin
      if (w_alloc_sub) r_alloc_id <= r_alloc_id + ID_W'(1);
      if (w_free_sub)  r_free_id  <= r_free_id + ID_W'(1);
      r_alloc_out <= w_alloc_out_nx;
      r_free_out  <= w_free_out_nx;
      if (w_mm)                r_err_mm <= 1'b1;
      else if (bus.err_clear)  r_err_mm <= 1'b0;
      if (w_alloc_ux || w_free_ux) r_err_ux <= 1'b1;
      else if (bus.err_clear)      r_err_ux <= 1'b0;
    end
  end

  // Response collector: pop in IDLE, capture the FIFO data one cycle later, hold until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= S_IDLE;
      r_last_free       <= 1'b1;
      r_sel_free        <= 1'b0;
      r_exp_alloc       <= '0;
      r_exp_free        <= '0;
      r_res_valid       <= 1'b0;
      r_res_is_free     <= 1'b0;
      r_res_id          <= '0;
      r_res_page_idx    <= '0;
      r_res_fail        <= 1'b0;
      r_res_fail_reason <= '0;
      r_res_origin_size <= '0;
      r_res_actual_size <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.alloc_rsp_fifo_not_empty || bus.free_rsp_fifo_not_empty) begin
            r_sel_free  <= w_grant_free;
            r_last_free <= w_grant_free;
            r_state     <= S_CAPT;
          end
        end
        S_CAPT: begin
          r_res_valid   <= 1'b1;
          r_res_is_free <= r_sel_free;
          r_res_id      <= w_cap_id;
          if (r_sel_free) begin
            r_res_page_idx    <= '0;
            r_res_fail        <= bus.free_rsp_fail;
            r_res_fail_reason <= bus.free_rsp_fail_reason;
            r_res_origin_size <= bus.free_rsp_origin_size;
            r_res_actual_size <= bus.free_rsp_actual_size;
            r_exp_free        <= r_exp_free + ID_W'(1);
          end else begin
            r_res_page_idx    <= bus.alloc_rsp_page_idx;
            r_res_fail        <= bus.alloc_rsp_fail;
            r_res_fail_reason <= bus.alloc_rsp_fail_reason;
            r_res_origin_size <= bus.alloc_rsp_origin_size;
            r_res_actual_size <= bus.alloc_rsp_actual_size;
            r_exp_alloc       <= r_exp_alloc + ID_W'(1);
          end
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.res_valid          = r_res_valid;
  assign bus.res_is_free        = r_res_is_free;
  assign bus.res_id             = r_res_id;
  assign bus.res_page_idx       = r_res_page_idx;
  assign bus.res_fail           = r_res_fail;
  assign bus.res_fail_reason    = r_res_fail_reason;
  assign bus.res_origin_size    = r_res_origin_size;
  assign bus.res_actual_size    = r_res_actual_size;
  assign bus.alloc_outstanding  = r_alloc_out;
  assign bus.free_outstanding   = r_free_out;
  assign bus.err_id_mismatch    = r_err_mm;
  assign bus.err_unexpected_rsp = r_err_ux;
endmodule

// File: tb/tb_mmu_client.sv
// Scoreboard bench for mmu_client: a small MMU response-FIFO model feeds the DUT, expected
// results are queued at stimulus time and checked by a monitor on each result handshake.
module tb_mmu_client;
  typedef struct packed {
    logic        is_free;
    logic [12:0] id;
    logic [14:0] idx;
    logic        fail;
    logic [1:0]  fr;
    logic [3:0]  os;
    logic [3:0]  as_;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mmu_client_if u_if ();
  mmu_client u_dut (.clk(clk), .rst_n(rst_n), .bus(u_if));

  res_t exp_q[$];
  res_t aq[$];
  res_t fq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
    end
  endtask

  // MMU response FIFOs: a pop seen this cycle presents the next entry in the following cycle.
  task automatic model_loop();
    logic pa, pf;
    res_t r;
    forever begin
      @(negedge clk);
      pa = u_if.alloc_rsp_pop;
      pf = u_if.free_rsp_pop;
      @(posedge clk);
      #1;
      if (pa) begin
        if (aq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL alloc_pop_empty: got pop want no pop");
        end else begin
          r = aq.pop_front();
          u_if.alloc_rsp_id          = r.id;
          u_if.alloc_rsp_page_idx    = r.idx;
          u_if.alloc_rsp_fail        = r.fail;
          u_if.alloc_rsp_fail_reason = r.fr;
          u_if.alloc_rsp_origin_size = r.os;
          u_if.alloc_rsp_actual_size = r.as_;
        end
      end
      if (pf) begin
        if (fq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL free_pop_empty: got pop want no pop");
        end else begin
          r = fq.pop_front();
          u_if.free_rsp_id          = r.id;
          u_if.free_rsp_fail        = r.fail;
          u_if.free_rsp_fail_reason = r.fr;
          u_if.free_rsp_origin_size = r.os;
          u_if.free_rsp_actual_size = r.as_;
        end
      end
      u_if.alloc_rsp_fifo_not_empty = (aq.size() != 0);
      u_if.free_rsp_fifo_not_empty  = (fq.size() != 0);
    end
  endtask

  task automatic monitor_loop();
    res_t got, want;
    int   cyc = 0;
    int   pop_cyc = -100;
    logic prev_v = 1'b0;
    logic prev_pop = 1'b0;
    logic pop_now;
    forever begin
      @(negedge clk);
      cyc++;
      pop_now = u_if.alloc_rsp_pop | u_if.free_rsp_pop;
      if (u_if.res_valid) chk("no_pop_while_valid", pop_now, 0);
      if (pop_now) begin
        chk("pop_single_cycle", prev_pop, 0);
        chk("one_pop_per_cycle", u_if.alloc_rsp_pop & u_if.free_rsp_pop, 0);
        pop_cyc = cyc;
      end
      prev_pop = pop_now;
      if (u_if.res_valid && !prev_v) chk("pop_to_valid_cycles", cyc - pop_cyc, 2);
      prev_v = u_if.res_valid;
      if (u_if.res_valid && u_if.res_ready) begin
        got = {u_if.res_is_free, u_if.res_id, u_if.res_page_idx, u_if.res_fail,
               u_if.res_fail_reason, u_if.res_origin_size, u_if.res_actual_size};
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_result: got 0x%0h want none", got);
        end else begin
          want = exp_q.pop_front();
          chk("result", got, want);
        end
      end
    end
  endtask

  task automatic push_rsp(input logic f, input logic [12:0] id, input logic [14:0] idx,
                          input logic fail, input logic [1:0] fr, input logic [3:0] os,
                          input logic [3:0] as_, input bit deliver);
    res_t r;
    r = {f, id, idx, fail, fr, os, as_};
    if (f) fq.push_back(r);
    else   aq.push_back(r);
    if (f) r.idx = '0;
    if (deliver) exp_q.push_back(r);
  endtask

  task automatic send_cmd(input logic f, input logic [3:0] cnt, input logic [14:0] idx,
                          input logic [12:0] eid);
    int k = 0;
    @(posedge clk); #1;
    u_if.cmd_valid = 1'b1;
    u_if.cmd_is_free = f;
    u_if.cmd_page_count = cnt;
    u_if.cmd_page_idx = idx;
    #1;
    while (!u_if.cmd_ready && k < 200) begin
      @(posedge clk); #2;
      k++;
    end
    chk("cmd_ready", u_if.cmd_ready, 1);
    if (f) begin
      chk("free_submit", u_if.free_req_submit, 1);
      chk("alloc_submit_quiet", u_if.alloc_req_submit, 0);
      chk("free_req_id", u_if.free_req_id, eid);
      chk("free_req_count", u_if.free_req_page_count, cnt);
      chk("free_req_idx", u_if.free_req_page_idx, idx);
    end else begin
      chk("alloc_submit", u_if.alloc_req_submit, 1);
      chk("free_submit_quiet", u_if.free_req_submit, 0);
      chk("alloc_req_id", u_if.alloc_req_id, eid);
      chk("alloc_req_count", u_if.alloc_req_page_count, cnt);
    end
    @(posedge clk); #1;
    u_if.cmd_valid = 1'b0;
  endtask

  task automatic probe_blocked(input logic f);
    @(posedge clk); #1;
    u_if.cmd_valid = 1'b1;
    u_if.cmd_is_free = f;
    #1;
    chk("blocked_ready", u_if.cmd_ready, 0);
    chk("blocked_alloc_submit", u_if.alloc_req_submit, 0);
    chk("blocked_free_submit", u_if.free_req_submit, 0);
    u_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((exp_q.size() != 0 || aq.size() != 0 || fq.size() != 0 || u_if.res_valid)
           && k < 5000) begin
      @(posedge clk);
      k++;
    end
    chk("drain_in_time", (k < 5000), 1);
    @(posedge clk); #1;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1;
    u_if.err_clear = 1'b1;
    @(posedge clk); #1;
    u_if.err_clear = 1'b0;
  endtask

  initial begin
    int k;
    logic [12:0] eid;
    u_if.cmd_valid = 0; u_if.cmd_is_free = 0; u_if.cmd_page_count = 0; u_if.cmd_page_idx = 0;
    u_if.alloc_req_fifo_full = 0; u_if.free_req_fifo_full = 0;
    u_if.alloc_rsp_fifo_not_empty = 0; u_if.free_rsp_fifo_not_empty = 0;
    u_if.alloc_rsp_id = 0; u_if.alloc_rsp_page_idx = 0; u_if.alloc_rsp_fail = 0;
    u_if.alloc_rsp_fail_reason = 0; u_if.alloc_rsp_origin_size = 0; u_if.alloc_rsp_actual_size = 0;
    u_if.free_rsp_id = 0; u_if.free_rsp_fail = 0; u_if.free_rsp_fail_reason = 0;
    u_if.free_rsp_origin_size = 0; u_if.free_rsp_actual_size = 0;
    u_if.res_ready = 1; u_if.err_clear = 0;
    fork
      model_loop();
      monitor_loop();
      begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res_valid", u_if.res_valid, 0);
    chk("rst_alloc_out", u_if.alloc_outstanding, 0);
    chk("rst_free_out", u_if.free_outstanding, 0);
    chk("rst_err_mm", u_if.err_id_mismatch, 0);
    chk("rst_err_ux", u_if.err_unexpected_rsp, 0);
    chk("rst_alloc_id", u_if.alloc_req_id, 0);
    chk("rst_submit", u_if.alloc_req_submit, 0);
    rst_n = 1'b1;

    // Single alloc round trip
    send_cmd(0, 4'd4, 15'd0, 13'd0);
    chk("t1_alloc_out", u_if.alloc_outstanding, 1);
    push_rsp(0, 13'd0, 15'h0040, 0, 2'd0, 4'd4, 4'd4, 1);
    wait_drain();
    chk("t2_alloc_out", u_if.alloc_outstanding, 0);

    // Both channels pending: grants alternate, free first since alloc went last
    send_cmd(0, 4'd1, 15'd0, 13'd1);
    send_cmd(0, 4'd2, 15'd0, 13'd2);
    send_cmd(1, 4'd3, 15'h1234, 13'd0);
    send_cmd(1, 4'd5, 15'h0777, 13'd1);
    chk("t3_alloc_out", u_if.alloc_outstanding, 2);
    chk("t3_free_out", u_if.free_outstanding, 2);
    push_rsp(0, 13'd1, 15'h0101, 0, 2'd0, 4'd1, 4'd1, 0);
    push_rsp(0, 13'd2, 15'h0202, 1, 2'd3, 4'd2, 4'd0, 0);
    push_rsp(1, 13'd0, 15'h7fff, 0, 2'd0, 4'd3, 4'd3, 0);
    push_rsp(1, 13'd1, 15'h0000, 1, 2'd1, 4'd5, 4'd2, 0);
    exp_q.push_back({1'b1, 13'd0, 15'h0000, 1'b0, 2'd0, 4'd3, 4'd3});
    exp_q.push_back({1'b0, 13'd1, 15'h0101, 1'b0, 2'd0, 4'd1, 4'd1});
    exp_q.push_back({1'b1, 13'd1, 15'h0000, 1'b1, 2'd1, 4'd5, 4'd2});
    exp_q.push_back({1'b0, 13'd2, 15'h0202, 1'b1, 2'd3, 4'd2, 4'd0});
    wait_drain();
    chk("t3_alloc_out_end", u_if.alloc_outstanding, 0);
    chk("t3_free_out_end", u_if.free_outstanding, 0);
    chk("t3_err_mm", u_if.err_id_mismatch, 0);

    // Alloc backpressure by FIFO full and by the outstanding limit; free still accepted
    u_if.alloc_req_fifo_full = 1'b1;
    probe_blocked(0);
    send_cmd(1, 4'd1, 15'h0010, 13'd2);
    u_if.alloc_req_fifo_full = 1'b0;
    for (int i = 0; i < 16; i++) send_cmd(0, 4'(i), 15'd0, 13'(3 + i));
    chk("t4_alloc_out_full", u_if.alloc_outstanding, 16);
    probe_blocked(0);
    send_cmd(1, 4'd2, 15'h0020, 13'd3);
    chk("t4_free_out", u_if.free_outstanding, 2);
    push_rsp(1, 13'd2, 15'd0, 0, 2'd0, 4'd1, 4'd1, 1);
    push_rsp(1, 13'd3, 15'd0, 0, 2'd0, 4'd2, 4'd2, 1);
    wait_drain();
    for (int i = 0; i < 16; i++)
      push_rsp(0, 13'(3 + i), 15'(16'h0100 + i), 0, 2'd0, 4'(i), 4'(i), 1);
    wait_drain();
    chk("t4_alloc_out_end", u_if.alloc_outstanding, 0);
    chk("t4_free_out_end", u_if.free_outstanding, 0);

    // Alloc id wrap across 8192 submits with in-order responses
    for (int i = 0; i < 8192; i++) begin
      eid = 13'(19 + i);
      send_cmd(0, 4'(i), 15'd0, eid);
      push_rsp(0, eid, 15'(i), 1'(i), 2'(i), 4'(i >> 2), 4'(i), 1);
    end
    wait_drain();
    chk("t5_wrap_err_mm", u_if.err_id_mismatch, 0);
    chk("t5_next_alloc_id", u_if.alloc_req_id, 19);

    // Id mismatch on free channel: 7 returned while 4 expected, still delivered
    send_cmd(1, 4'd3, 15'h0abc, 13'd4);
    push_rsp(1, 13'd7, 15'd0, 1, 2'd2, 4'd3, 4'd0, 1);
    wait_drain();
    chk("t5_err_mm_set", u_if.err_id_mismatch, 1);
    chk("t5_err_ux_quiet", u_if.err_unexpected_rsp, 0);
    pulse_clear();
    chk("t5_err_mm_clear", u_if.err_id_mismatch, 0);

    // Free response with nothing outstanding
    push_rsp(1, 13'd5, 15'd0, 0, 2'd0, 4'd1, 4'd1, 1);
    wait_drain();
    chk("t6_err_ux_set", u_if.err_unexpected_rsp, 1);
    chk("t6_free_out_zero", u_if.free_outstanding, 0);
    chk("t6_err_mm_quiet", u_if.err_id_mismatch, 0);
    pulse_clear();
    chk("t6_err_ux_clear", u_if.err_unexpected_rsp, 0);

    // Reset while holding a result
    u_if.res_ready = 1'b0;
    send_cmd(0, 4'd2, 15'd0, 13'd19);
    push_rsp(0, 13'd19, 15'h0055, 0, 2'd0, 4'd2, 4'd2, 0);
    k = 0;
    while (!u_if.res_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("t6_hold_valid", u_if.res_valid, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("t6_hold_stable_valid", u_if.res_valid, 1);
    chk("t6_hold_stable_id", u_if.res_id, 19);
    chk("t6_hold_stable_idx", u_if.res_page_idx, 15'h0055);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_res_valid", u_if.res_valid, 0);
    chk("t6_rst_res_id", u_if.res_id, 0);
    chk("t6_rst_alloc_id", u_if.alloc_req_id, 0);
    chk("t6_rst_alloc_out", u_if.alloc_outstanding, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    u_if.res_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("final_res_valid", u_if.res_valid, 0);
    chk("final_scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
